spi_slave_mem_param: RTL

SPI_SLAVE_MEM_PARAM -- requirements
Module: spi_slave_mem_param

---
 rtl/spi_slave_mem_param_if.sv | 16 +
 rtl/spi_slave_mem_if.sv | 2 +
 rtl/spi_slave_mem_param.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/spi_slave_mem_param_if.sv
// Serial bus bundle for spi_slave_mem_param.
//   SS_n  : slave select, active low (master -> slave)
//   MOSI  : serial data in, MSB first (master -> slave)
//   MISO  : serial data out, MSB first (slave -> master)
//   busy  : frame in progress (slave -> master)
//   abort : one-cycle pulse when a frame is cut short (slave -> master)
interface spi_slave_mem_param_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic busy;
  logic abort;

  modport master (output SS_n, output MOSI, input MISO, input busy, input abort);
  modport slave  (input SS_n, input MOSI, output MISO, output busy, output abort);
endinterface

// File: rtl/spi_slave_mem_if.sv
// Deliberately empty. The interface used by spi_slave_mem_param is declared
// in rtl/spi_slave_mem_param_if.sv.

// File: rtl/spi_slave_mem_param.sv
// Frame-based serial slave fronting a 2**ADDR_WIDTH x DATA_WIDTH memory.
// A frame starts with a 2-bit command:
//   00 set write pointer, 01 write data, 10 set read pointer, 11 read data.
// Ports:
//   clk   : system clock, MOSI/SS_n sampled on the rising edge
//   rst_n : synchronous active-low reset (memory contents are kept)
//   spi   : slave modport carrying SS_n, MOSI, MISO, busy, abort
module spi_slave_mem_param #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AUTO_INC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_slave_mem_param_if.slave  spi
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned SH_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(SH_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_LOAD, RD_DATA, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SH_W-1:0]        shreg_q, shreg_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]  rbuf_q, rbuf_d;
  logic                   miso_q, miso_d;
  logic                   abort_q, abort_d;
  logic                   mem_we;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic [SH_W-1:0]        shift_in;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  // Shift register contents including the bit sampled on this edge
  assign shift_in = {shreg_q[SH_W-2:0], spi.MOSI};

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    rbuf_d    = rbuf_q;
    miso_d    = 1'b0;
    abort_d   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = DATA_WIDTH'(shift_in);

    if (spi.SS_n && state_q != IDLE && state_q != DONE) begin
      // Select released mid-frame: drop everything captured so far
      state_d = IDLE;
      abort_d = 1'b1;
      cnt_d   = '0;
      shreg_d = '0;
      rbuf_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!spi.SS_n) begin
            state_d = CMD;
            shreg_d = SH_W'(spi.MOSI);  // cmd[1] parked in bit 0
          end
        end
        CMD: begin
          cnt_d   = '0;
          shreg_d = '0;
          unique case ({shreg_q[0], spi.MOSI})
            2'b00:   state_d = WR_ADDR;
            2'b01:   state_d = WR_DATA;
            2'b10:   state_d = RD_ADDR;
            default: state_d = RD_LOAD;
          endcase
        end
        WR_ADDR, RD_ADDR: begin
          shreg_d = shift_in;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == ADDR_LAST) begin
            if (state_q == WR_ADDR) wr_addr_d = ADDR_WIDTH'(shift_in);
            else                    rd_addr_d = ADDR_WIDTH'(shift_in);
            state_d = DONE;
          end
        end
        WR_DATA: begin
          shreg_d = shift_in;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == DATA_LAST) begin
            mem_we = 1'b1;
            if (AUTO_INC != 0) wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
            state_d = DONE;
          end
        end
        RD_LOAD: begin
          rbuf_d  = mem[rd_addr_q];
          cnt_d   = '0;
          state_d = RD_DATA;
        end
        RD_DATA: begin
          miso_d = rbuf_q[DATA_WIDTH-1];
          rbuf_d = rbuf_q << 1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == DATA_LAST) begin
            if (AUTO_INC != 0) rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            state_d = DONE;
          end
        end
        DONE: begin
          if (spi.SS_n) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rbuf_q    <= '0;
      miso_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rbuf_q    <= rbuf_d;
      miso_q    <= miso_d;
      abort_q   <= abort_d;
    end
  end

  // Storage array, deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[wr_addr_q] <= mem_wdata;
  end

  assign spi.MISO  = miso_q;
  assign spi.abort = abort_q;
  assign spi.busy  = (state_q != IDLE);

endmodule
